// File: rtl/red_pitaya_sh_trig_gen.sv
// Sample-and-hold trigger generator for the PID S&H input.
// Drives a high level for a hold window, then blanks the PID settle window,
// then tracks until the next trigger. Triggers come from a free-running
// period counter (mode 0) or from a synchronized external edge (mode 1).
module red_pitaya_sh_trig_gen #(
    parameter int BLANK_LEN = 63,
    parameter int PW        = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic                ext_trig_i,
    input  logic [PW-1:0]       set_period_i,
    input  logic [PW-1:0]       set_hold_i,
    input  logic signed [13:0]  set_hi_i,
    input  logic signed [13:0]  set_lo_i,
    output logic signed [13:0]  dat_o,
    output logic                hold_o,
    output logic                blank_o,
    output logic                trig_o,
    output logic [15:0]         hold_num_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BLANK,
        ST_TRACK
    } state_t;

    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_LEN - 1);
    localparam logic [PW-1:0] ONE        = PW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_trig_s1;
    logic          r_trig_s2;
    logic          r_trig_d;
    logic [PW-1:0] r_per_cnt;
    logic [PW-1:0] r_per_last;
    logic [PW-1:0] r_phase_cnt;
    logic [PW-1:0] r_hold_last;
    logic          w_trig_edge;
    logic          w_per_wrap;
    logic          w_hold_done;
    logic          w_blank_done;
    logic          w_hold_entry;

    // Edge is taken on the synchronized copy, so a raw input edge reaches
    // HOLD on the third clock edge.
    assign w_trig_edge  = r_trig_s2 & ~r_trig_d;
    // Counters compare against "last" values (length-1), so zero settings
    // behave as length 1.
    assign w_per_wrap   = (r_per_cnt == r_per_last);
    assign w_hold_done  = (r_phase_cnt == r_hold_last);
    assign w_blank_done = (r_phase_cnt == BLANK_LAST);

    // Two-flop synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what forms the shift chain.
            r_trig_s1 <= ext_trig_i;
            r_trig_s2 <= r_trig_s1;
            r_trig_d  <= r_trig_s2;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; a period wrap in free-run restarts HOLD from any active state.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        w_state_nxt  = r_state;
        w_hold_entry = 1'b0;
        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_hold_entry = !mode_i || w_trig_edge;
                ST_HOLD: begin
                    if (!mode_i && w_per_wrap) w_hold_entry = 1'b1;
                    else if (w_hold_done)      w_state_nxt  = ST_BLANK;
                end
                ST_BLANK: begin
                    if (!mode_i && w_per_wrap) w_hold_entry = 1'b1;
                    else if (w_blank_done)     w_state_nxt  = ST_TRACK;
                end
                ST_TRACK: w_hold_entry = mode_i ? w_trig_edge : w_per_wrap;
                default:  w_state_nxt  = ST_IDLE;
            endcase
            if (w_hold_entry) w_state_nxt = ST_HOLD;
        end
    end

    // Period/phase counters; settings are latched only on HOLD entry.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_per_cnt   <= '0;
            r_per_last  <= '0;
            r_phase_cnt <= '0;
            r_hold_last <= '0;
        end else if (w_hold_entry) begin
            r_per_cnt   <= '0;
            r_phase_cnt <= '0;
            r_per_last  <= (set_period_i == '0) ? '0 : set_period_i - ONE;
            r_hold_last <= (set_hold_i == '0)   ? '0 : set_hold_i - ONE;
        end else if (w_state_nxt == ST_IDLE) begin
            r_per_cnt   <= '0;
            r_per_last  <= '0;
            r_phase_cnt <= '0;
            r_hold_last <= '0;
        end else begin
            r_per_cnt <= w_per_wrap ? '0 : r_per_cnt + ONE;
            if (r_state == ST_HOLD && w_state_nxt == ST_BLANK)
                r_phase_cnt <= '0;
            else if (r_state == ST_HOLD || r_state == ST_BLANK)
                r_phase_cnt <= r_phase_cnt + ONE;
        end
    end

    // Registered outputs decoded from the next state so they track r_state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dat_o      <= '0;
            hold_o     <= 1'b0;
            blank_o    <= 1'b0;
            trig_o     <= 1'b0;
            hold_num_o <= '0;
        end else begin
            dat_o   <= (w_state_nxt == ST_HOLD) ? set_hi_i : set_lo_i;
            hold_o  <= (w_state_nxt == ST_HOLD);
            blank_o <= (w_state_nxt == ST_BLANK);
            trig_o  <= w_hold_entry;
            if (w_hold_entry) hold_num_o <= hold_num_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_red_pitaya_sh_trig_gen.sv
// Directed bench for red_pitaya_sh_trig_gen: free-run, overlap, single-shot,
// boundaries, enable drop and asynchronous reset.
module tb_red_pitaya_sh_trig_gen;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               enable_i;
    logic               mode_i;
    logic               ext_trig_i;
    logic [31:0]        set_period_i;
    logic [31:0]        set_hold_i;
    logic signed [13:0] set_hi_i;
    logic signed [13:0] set_lo_i;
    logic signed [13:0] dat_o;
    logic               hold_o;
    logic               blank_o;
    logic               trig_o;
    logic [15:0]        hold_num_o;

    int n_vec = 0;
    int n_err = 0;

    red_pitaya_sh_trig_gen dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .mode_i       (mode_i),
        .ext_trig_i   (ext_trig_i),
        .set_period_i (set_period_i),
        .set_hold_i   (set_hold_i),
        .set_hi_i     (set_hi_i),
        .set_lo_i     (set_lo_i),
        .dat_o        (dat_o),
        .hold_o       (hold_o),
        .blank_o      (blank_o),
        .trig_o       (trig_o),
        .hold_num_o   (hold_num_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_hold, n_blank, n_trig, n_track, n_hi, first_blank, run, max_run;

        rstn_i = 1'b0; enable_i = 1'b0; mode_i = 1'b0; ext_trig_i = 1'b0;
        set_period_i = 32'd200; set_hold_i = 32'd10;
        set_hi_i = 14'sd1000; set_lo_i = -14'sd1000;

        // Reset state
        step(2);
        check("rst_dat",  32'(dat_o),      32'(14'sd0));
        check("rst_hold", 32'(hold_o),     32'd0);
        check("rst_blank",32'(blank_o),    32'd0);
        check("rst_trig", 32'(trig_o),     32'd0);
        check("rst_num",  32'(hold_num_o), 32'd0);
        rstn_i = 1'b1;
        step(1);
        check("idle_dat_lo", 32'(dat_o), 32'(-14'sd1000));
        check("idle_hold",   32'(hold_o), 32'd0);

        // Free-run 200/10: 10 hold, 63 blank, 127 track per period
        enable_i = 1'b1;
        step(1);
        check("fr_hold_entry", 32'(hold_o),     32'd1);
        check("fr_trig_entry", 32'(trig_o),     32'd1);
        check("fr_num1",       32'(hold_num_o), 32'd1);
        check("fr_dat_hi",     32'(dat_o),      32'(14'sd1000));
        n_hold = 0; n_blank = 0; n_trig = 0; n_track = 0; n_hi = 0; first_blank = -1;
        for (int i = 0; i < 200; i++) begin
            n_hold  += int'(hold_o);
            n_blank += int'(blank_o);
            n_trig  += int'(trig_o);
            n_track += int'(!hold_o && !blank_o);
            n_hi    += int'(dat_o == 14'sd1000);
            if (blank_o && first_blank < 0) first_blank = i;
            step(1);
        end
        check("fr_hold_cnt",   32'(n_hold),      32'd10);
        check("fr_blank_cnt",  32'(n_blank),     32'd63);
        check("fr_track_cnt",  32'(n_track),     32'd127);
        check("fr_trig_cnt",   32'(n_trig),      32'd1);
        check("fr_hi_cnt",     32'(n_hi),        32'd10);
        check("fr_blank_first",32'(first_blank), 32'd10);
        check("fr_trig_200",   32'(trig_o),      32'd1);
        check("fr_num2",       32'(hold_num_o),  32'd2);

        // Level inputs are sampled every cycle
        set_hi_i = 14'sd777;
        step(1);
        check("hi_live",     32'(dat_o),  32'(14'sd777));
        check("hi_live_trig",32'(trig_o), 32'd0);
        set_hi_i = 14'sd1000;

        // Enable drop returns to IDLE, count preserved
        enable_i = 1'b0;
        step(1);
        check("dis_hold", 32'(hold_o),     32'd0);
        check("dis_dat",  32'(dat_o),      32'(-14'sd1000));
        check("dis_num",  32'(hold_num_o), 32'd2);

        // Overlap 50/40: restart every 50, blank at most 10
        set_period_i = 32'd50; set_hold_i = 32'd40; enable_i = 1'b1;
        step(1);
        check("ov_trig", 32'(trig_o),     32'd1);
        check("ov_num3", 32'(hold_num_o), 32'd3);
        n_hold = 0; n_trig = 0; n_track = 0; run = 0; max_run = 0;
        for (int i = 0; i < 150; i++) begin
            n_hold  += int'(hold_o);
            n_trig  += int'(trig_o);
            n_track += int'(!hold_o && !blank_o);
            run = blank_o ? run + 1 : 0;
            if (run > max_run) max_run = run;
            step(1);
        end
        check("ov_trig_cnt",  32'(n_trig),     32'd3);
        check("ov_hold_cnt",  32'(n_hold),     32'd120);
        check("ov_track_cnt", 32'(n_track),    32'd0);
        check("ov_blank_max", 32'(max_run),    32'd10);
        check("ov_trig_150",  32'(trig_o),     32'd1);
        check("ov_num6",      32'(hold_num_o), 32'd6);

        // Enable drop mid-BLANK, then re-enable in mode 0
        step(42);
        check("mb_blank", 32'(blank_o), 32'd1);
        enable_i = 1'b0;
        step(1);
        check("mb_hold",  32'(hold_o),     32'd0);
        check("mb_blank0",32'(blank_o),    32'd0);
        check("mb_dat",   32'(dat_o),      32'(-14'sd1000));
        check("mb_num",   32'(hold_num_o), 32'd6);
        enable_i = 1'b1;
        step(1);
        check("re_hold", 32'(hold_o),     32'd1);
        check("re_trig", 32'(trig_o),     32'd1);
        check("re_num7", 32'(hold_num_o), 32'd7);

        // hold=0 acts as a 1-cycle hold
        enable_i = 1'b0;
        step(1);
        set_period_i = 32'd300; set_hold_i = 32'd0; enable_i = 1'b1;
        step(1);
        check("h0_hold", 32'(hold_o),     32'd1);
        check("h0_num8", 32'(hold_num_o), 32'd8);
        step(1);
        check("h0_hold_off", 32'(hold_o),  32'd0);
        check("h0_blank",    32'(blank_o), 32'd1);

        // period=0 acts as period 1: a trigger every cycle, then count wrap
        enable_i = 1'b0;
        step(1);
        set_period_i = 32'd0; set_hold_i = 32'd5; enable_i = 1'b1;
        step(1);
        check("p0_num9", 32'(hold_num_o), 32'd9);
        step(1);
        check("p0_trig",  32'(trig_o),     32'd1);
        check("p0_hold",  32'(hold_o),     32'd1);
        check("p0_num10", 32'(hold_num_o), 32'd10);
        step(1);
        check("p0_num11", 32'(hold_num_o), 32'd11);
        step(65524);
        check("wrap_ffff", 32'(hold_num_o), 32'h0000_FFFF);
        step(1);
        check("wrap_zero", 32'(hold_num_o), 32'd0);
        check("wrap_trig", 32'(trig_o),     32'd1);

        // Single-shot: 3-cycle latency, edges in HOLD/BLANK ignored
        enable_i = 1'b0;
        step(1);
        check("ss_num_kept", 32'(hold_num_o), 32'd0);
        mode_i = 1'b1; set_period_i = 32'd20; set_hold_i = 32'd10; enable_i = 1'b1;
        step(2);
        check("ss_idle", 32'(hold_o), 32'd0);
        ext_trig_i = 1'b1;
        step(1);
        check("ss_lat1", 32'(hold_o), 32'd0);
        step(1);
        check("ss_lat2", 32'(hold_o), 32'd0);
        step(1);
        check("ss_lat3", 32'(hold_o),     32'd1);
        check("ss_trig", 32'(trig_o),     32'd1);
        check("ss_num1", 32'(hold_num_o), 32'd1);
        ext_trig_i = 1'b0;
        n_hold = 0; n_blank = 0; n_trig = 0;
        for (int i = 1; i < 80; i++) begin
            step(1);
            ext_trig_i = (i >= 2 && i < 4) || (i >= 20 && i < 23);
            n_hold  += int'(hold_o);
            n_blank += int'(blank_o);
            n_trig  += int'(trig_o);
        end
        check("ss_ign_trig",  32'(n_trig),     32'd0);
        check("ss_hold_cnt",  32'(n_hold),     32'd9);
        check("ss_blank_cnt", 32'(n_blank),    32'd63);
        check("ss_track",     32'(hold_o | blank_o), 32'd0);
        check("ss_num_still", 32'(hold_num_o), 32'd1);
        ext_trig_i = 1'b1;
        step(2);
        check("ss_re_wait", 32'(hold_o), 32'd0);
        step(1);
        check("ss_re_hold", 32'(hold_o),     32'd1);
        check("ss_re_num2", 32'(hold_num_o), 32'd2);

        // Enable rise coincident with a detected edge enters HOLD
        enable_i = 1'b0; ext_trig_i = 1'b0;
        step(3);
        check("co_idle", 32'(hold_o),     32'd0);
        check("co_num",  32'(hold_num_o), 32'd2);
        ext_trig_i = 1'b1;
        step(2);
        enable_i = 1'b1;
        step(1);
        check("co_hold", 32'(hold_o),     32'd1);
        check("co_num3", 32'(hold_num_o), 32'd3);

        // Asynchronous reset mid-HOLD clears outputs without a clock edge
        step(3);
        check("ar_pre_hold", 32'(hold_o), 32'd1);
        #3;
        rstn_i = 1'b0;
        #1;
        check("ar_hold",  32'(hold_o),     32'd0);
        check("ar_dat",   32'(dat_o),      32'(14'sd0));
        check("ar_blank", 32'(blank_o),    32'd0);
        check("ar_num",   32'(hold_num_o), 32'd0);
        step(1);
        mode_i = 1'b0; ext_trig_i = 1'b0; rstn_i = 1'b1;
        step(1);
        check("ar_resume_hold", 32'(hold_o),     32'd1);
        check("ar_resume_trig", 32'(trig_o),     32'd1);
        check("ar_resume_num",  32'(hold_num_o), 32'd1);
        check("ar_resume_dat",  32'(dat_o),      32'(14'sd1000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
